// File: rtl/note_tone_generator.sv
// Twelve-note square-wave tone generator with a button-stepped octave register.
// Each enabled note runs its own period counter. The output is high for the first
// half of the period and low for the rest. The period is the 10 MHz base divisor
// shifted right by the current octave.
module note_tone_generator #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned NUM_OCT = 4,
   parameter int unsigned CLK_HZ  = 10000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       oct_up,
   input  logic                       oct_dn,
   input  logic [11:0]                note_en,
   output logic [$clog2(NUM_OCT)-1:0] octave,
   output logic [11:0]                tone,
   output logic                       oct_chg
);

   localparam int unsigned OCT_W = $clog2(NUM_OCT);

   // Reject parameter values the fixed base table cannot support.
   if (CNT_W < 16) begin : g_bad_cnt_w
      $error("CNT_W must be at least 16");
   end
   if (NUM_OCT < 2 || NUM_OCT > 8) begin : g_bad_num_oct
      $error("NUM_OCT must be in 2..8");
   end
   if (CLK_HZ == 0) begin : g_bad_clk_hz
      $error("CLK_HZ must be non-zero");
   end

   // Full-period divisors for C..B at octave 0, in 10 MHz clock cycles.
   function automatic logic [15:0] base_period(input int n);
      logic [15:0] p;
      case (n)
         0:       p = 16'd38223;
         1:       p = 16'd36077;
         2:       p = 16'd34052;
         3:       p = 16'd32141;
         4:       p = 16'd30337;
         5:       p = 16'd28635;
         6:       p = 16'd27027;
         7:       p = 16'd25511;
         8:       p = 16'd24079;
         9:       p = 16'd22727;
         10:      p = 16'd21452;
         default: p = 16'd20248;
      endcase
      return p;
   endfunction

   logic             up_s1_q, up_s2_q, up_prev_q;
   logic             dn_s1_q, dn_s2_q, dn_prev_q;
   logic             up_edge, dn_edge, step;
   logic [OCT_W-1:0] octave_q, octave_d;
   logic             oct_chg_q, oct_chg_d;
   logic [11:0]      en_q;
   logic [11:0]      tone_q, tone_d;
   logic [CNT_W-1:0] cnt_q  [12];
   logic [CNT_W-1:0] cnt_d  [12];
   logic [CNT_W-1:0] period [12];
   logic [CNT_W-1:0] half   [12];

   // Two-flop synchronisers plus the previous-value flops for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_s1_q   <= 1'b0;
         up_s2_q   <= 1'b0;
         up_prev_q <= 1'b0;
         dn_s1_q   <= 1'b0;
         dn_s2_q   <= 1'b0;
         dn_prev_q <= 1'b0;
      end else begin
         up_s1_q   <= oct_up;
         up_s2_q   <= up_s1_q;
         up_prev_q <= up_s2_q;
         dn_s1_q   <= oct_dn;
         dn_s2_q   <= dn_s1_q;
         dn_prev_q <= dn_s2_q;
      end
   end

   assign up_edge = up_s2_q & ~up_prev_q;
   assign dn_edge = dn_s2_q & ~dn_prev_q;
   // Simultaneous up and down edges cancel out.
   assign step    = up_edge ^ dn_edge;

   // Next octave with wrap-around in both directions.
   always_comb begin
      octave_d  = octave_q;
      oct_chg_d = 1'b0;
      if (step) begin
         oct_chg_d = 1'b1;
         if (up_edge) begin
            octave_d = (octave_q == OCT_W'(NUM_OCT - 1)) ? '0 : octave_q + 1'b1;
         end else begin
            octave_d = (octave_q == '0) ? OCT_W'(NUM_OCT - 1) : octave_q - 1'b1;
         end
      end
   end

   // Octave register and its one-cycle change strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         octave_q  <= '0;
         oct_chg_q <= 1'b0;
      end else begin
         octave_q  <= octave_d;
         oct_chg_q <= oct_chg_d;
      end
   end

   // Per-note period and high-phase length at the current octave.
   always_comb begin
      for (int n = 0; n < 12; n++) begin
         period[n] = CNT_W'(base_period(n)) >> octave_q;
         half[n]   = period[n] >> 1;
      end
   end

   // Counter next state. A note that was off last cycle starts at phase 0, so its
   // first high phase is full length. An octave step also restarts every counter.
   always_comb begin
      for (int n = 0; n < 12; n++) begin
         cnt_d[n] = '0;
         if (note_en[n] && en_q[n] && !step && (cnt_q[n] != period[n] - 1'b1)) begin
            cnt_d[n] = cnt_q[n] + 1'b1;
         end
         tone_d[n] = note_en[n] & (cnt_d[n] < half[n]);
      end
   end

   // Per-note counters, registered tone outputs and the enable history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q   <= '0;
         tone_q <= '0;
         for (int n = 0; n < 12; n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         en_q   <= note_en;
         tone_q <= tone_d;
         for (int n = 0; n < 12; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

   assign octave  = octave_q;
   assign oct_chg = oct_chg_q;
   assign tone    = tone_q;

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: a cycle model that works from phase arithmetic,
// plus measured run lengths checked against hand-computed literals.
module tb_note_tone_generator;

   localparam int NUM_OCT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        oct_up = 1'b0;
   logic        oct_dn = 1'b0;
   logic [11:0] note_en = 12'h000;
   logic [1:0]  octave;
   logic [11:0] tone;
   logic        oct_chg;

   always #5 clk = ~clk;

   note_tone_generator #(
      .CNT_W   (16),
      .NUM_OCT (NUM_OCT),
      .CLK_HZ  (10000000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .oct_up  (oct_up),
      .oct_dn  (oct_dn),
      .note_en (note_en),
      .octave  (octave),
      .tone    (tone),
      .oct_chg (oct_chg)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Model state: raw button samples, octave, per-note phase origin.
   int       base [12] = '{38223, 36077, 34052, 32141, 30337, 28635,
                           27027, 25511, 24079, 22727, 21452, 20248};
   bit       up_h [3];
   bit       dn_h [3];
   int       m_oct;
   bit       m_chg;
   bit [11:0] m_tone;
   bit       m_act [12];
   int       m_start [12];

   // Advance the model on each edge, then compare the DUT just after the edge.
   always @(posedge clk) begin
      bit u, d;
      int p;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            up_h[i] = 1'b0;
            dn_h[i] = 1'b0;
         end
         m_oct  = 0;
         m_chg  = 1'b0;
         m_tone = '0;
         for (int n = 0; n < 12; n++) m_act[n] = 1'b0;
      end else begin
         // A raw rise first sampled two edges ago takes effect on this edge.
         u = up_h[1] && !up_h[2];
         d = dn_h[1] && !dn_h[2];
         up_h[2] = up_h[1]; up_h[1] = up_h[0]; up_h[0] = oct_up;
         dn_h[2] = dn_h[1]; dn_h[1] = dn_h[0]; dn_h[0] = oct_dn;
         m_chg = u ^ d;
         if (u && !d) m_oct = (m_oct + 1) % NUM_OCT;
         else if (d && !u) m_oct = (m_oct + NUM_OCT - 1) % NUM_OCT;
         for (int n = 0; n < 12; n++) begin
            if (!note_en[n]) begin
               m_act[n]  = 1'b0;
               m_tone[n] = 1'b0;
            end else begin
               if (!m_act[n] || m_chg) begin
                  m_start[n] = cyc;
                  m_act[n]   = 1'b1;
               end
               p = base[n] >> m_oct;
               m_tone[n] = ((cyc - m_start[n]) % p) < (p / 2);
            end
         end
      end
      cyc++;
      #1;
      check("tone", tone, m_tone);
      check("octave", octave, m_oct);
      check("oct_chg", oct_chg, m_chg);
   end

   // Raise the given buttons for 10 cycles, release, and count oct_chg pulses seen.
   task automatic press(input bit up, input bit dn, output int pulses);
      pulses = 0;
      oct_up = up;
      oct_dn = dn;
      repeat (10) begin
         @(negedge clk);
         if (oct_chg) pulses++;
      end
      oct_up = 1'b0;
      oct_dn = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (oct_chg) pulses++;
      end
   endtask

   // Count consecutive cycles tone[n] sits at level, starting at the current negedge.
   task automatic run_len(input int n, input bit level, input int limit, output int len);
      len = 0;
      while (tone[n] == level && len < limit) begin
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      int p, len, lc, lb_hi, lb_lo, k;
      int seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: nothing moves.
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (tone != 12'h000 || oct_chg || octave != 2'd0) seen++;
      end
      check("idle_activity", seen, 0);

      // C at octave 0.
      note_en = 12'h001;
      @(negedge clk);
      check("c0_first", tone, 12'h001);
      run_len(0, 1'b1, 40000, len);
      check("c0_high", len, 19111);
      run_len(0, 1'b0, 40000, len);
      check("c0_low", len, 19112);
      check("c0_rehigh", tone, 12'h001);
      note_en = 12'h000;
      @(negedge clk);

      // Two up steps, then A at octave 2.
      press(1'b1, 1'b0, p);
      press(1'b1, 1'b0, k);
      check("two_up_pulses", p + k, 2);
      check("two_up_octave", octave, 2);
      note_en = 12'h200;
      @(negedge clk);
      run_len(9, 1'b1, 10000, len);
      check("a2_high", len, 2840);
      run_len(9, 1'b0, 10000, len);
      check("a2_low", len, 2841);
      note_en = 12'h000;
      @(negedge clk);

      // Wrap-around both ways and cancelling simultaneous presses.
      press(1'b1, 1'b0, p);
      check("up_to_3", octave, 3);
      press(1'b1, 1'b0, p);
      check("wrap_up", octave, 0);
      check("wrap_up_pulse", p, 1);
      press(1'b0, 1'b1, p);
      check("wrap_dn", octave, 3);
      press(1'b1, 1'b1, p);
      check("both_octave", octave, 3);
      check("both_pulses", p, 0);

      // C and B running, octave stepped mid-period (B in its low phase).
      press(1'b1, 1'b0, p);
      check("back_to_0", octave, 0);
      note_en = 12'h801;
      repeat (10500) @(negedge clk);
      check("cb_before", tone, 12'h001);
      oct_up = 1'b1;
      k = 0;
      while (!oct_chg && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("cb_chg_seen", oct_chg, 1);
      check("cb_octave", octave, 1);
      check("cb_restart", tone, 12'h801);
      fork
         run_len(0, 1'b1, 20000, lc);
         begin
            run_len(11, 1'b1, 20000, lb_hi);
            run_len(11, 1'b0, 20000, lb_lo);
         end
      join
      oct_up = 1'b0;
      check("c1_high", lc, 9555);
      check("b1_high", lb_hi, 5062);
      check("b1_low", lb_lo, 5062);
      note_en = 12'h000;
      repeat (5) @(negedge clk);

      // Reset in the middle of an E high phase.
      note_en = 12'h010;
      repeat (100) @(negedge clk);
      check("e_pre_reset", tone, 12'h010);
      rst = 1'b1;
      #1;
      check("rst_tone", tone, 0);
      check("rst_octave", octave, 0);
      check("rst_chg", oct_chg, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_len(4, 1'b1, 20000, len);
      check("e0_high", len, 15168);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
